io_scan_controller: RTL and testbench

//  Sits between the CPU data path and the IO pin shell. Holds 16 IO bytes (addresses 0-15):

---
 rtl/io_scan_controller.sv | 182 ++++++++++++++++++
 tb/tb_io_scan_controller.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_scan_controller.sv
// io_scan_controller: 16 IO bytes in two 8-slot ports. The two ports are scanned in
// lockstep through external slot multiplexers. The CPU accesses the byte and direction
// registers with single-cycle strobes.
module io_scan_controller #(
    parameter int SETTLE_CYC = 2,
    parameter int SLOT_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [15:0]       ioaddr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              rd_valid,
    output logic [SLOT_W-1:0] p0_sel,
    output logic [SLOT_W-1:0] p1_sel,
    output logic [7:0]        p0_out,
    output logic [7:0]        p1_out,
    output logic              p0_oe,
    output logic              p1_oe,
    input  logic [7:0]        p0_in,
    input  logic [7:0]        p1_in,
    output logic              scan_done,
    output logic [1:0]        state_dbg
);

    // CPU handshake: io_rd / io_wr are single-cycle strobes with no backpressure.
    // The CPU is always ready. A read strobe in cycle N produces rd_valid=1 in
    // cycle N+1, and rdata is valid only in that cycle. If a write and a read
    // target the same address in one cycle, the read returns the pre-write value.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_SETTLE = 2'd2,
        S_SAMPLE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SLOT_W-1:0] slot;
    logic [3:0]        cnt;
    logic [7:0]        out_reg [16];
    logic [7:0]        in_reg  [16];
    logic [15:0]       dir;

    logic [3:0]        lo_idx;
    logic [3:0]        hi_idx;
    logic              settle_last;
    logic              byte_hit;
    logic              dir_hit;

    // The port 0 slot maps to byte n, and the port 1 slot maps to byte n+8.
    assign lo_idx      = {1'b0, slot};
    assign hi_idx      = {1'b1, slot};
    assign settle_last = (cnt == 4'(SETTLE_CYC - 1));
    assign byte_hit    = (ioaddr[15:4] == 12'h000);
    assign dir_hit     = (ioaddr == 16'h0010);

    assign p0_sel    = slot;
    assign p1_sel    = slot;
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and pin outputs. During SETUP, oe is held low for bus turnaround.
    always_comb begin
        state_nxt = state;
        p0_out    = 8'h00;
        p1_out    = 8'h00;
        p0_oe     = 1'b0;
        p1_oe     = 1'b0;
        scan_done = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_SETUP;
            end
            S_SETUP: begin
                p0_out    = out_reg[lo_idx];
                p1_out    = out_reg[hi_idx];
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                p0_out = out_reg[lo_idx];
                p1_out = out_reg[hi_idx];
                p0_oe  = dir[lo_idx];
                p1_oe  = dir[hi_idx];
                if (settle_last) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                p0_out    = out_reg[lo_idx];
                p1_out    = out_reg[hi_idx];
                p0_oe     = dir[lo_idx];
                p1_oe     = dir[hi_idx];
                scan_done = (slot == '1);
                state_nxt = S_SETUP;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Slot pointer and settle counter. The counter is cleared in SETUP and counts through SETTLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot <= '0;
            cnt  <= 4'd0;
        end else begin
            case (state)
                S_IDLE:   slot <= '0;
                S_SETUP:  cnt  <= 4'd0;
                S_SETTLE: cnt  <= cnt + 4'd1;
                S_SAMPLE: slot <= slot + SLOT_W'(1);
                default:  cnt  <= 4'd0;
            endcase
        end
    end

    // Input capture. Only slots whose direction is input are overwritten in SAMPLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                in_reg[i] <= 8'h00;
            end
        end else if (state == S_SAMPLE) begin
            if (!dir[lo_idx]) begin
                in_reg[lo_idx] <= p0_in;
            end
            if (!dir[hi_idx]) begin
                in_reg[hi_idx] <= p1_in;
            end
        end
    end

    // CPU writes to the output bytes (independent of direction) and to the direction register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                out_reg[i] <= 8'h00;
            end
            dir <= 16'h0000;
        end else if (io_wr) begin
            if (byte_hit) begin
                out_reg[ioaddr[3:0]] <= wdata[7:0];
            end else if (dir_hit) begin
                dir <= wdata;
            end
        end
    end

    // Registered CPU read. Output bytes read back the driven value, and input bytes read the sampled value.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata    <= 16'h0000;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= io_rd;
            if (io_rd) begin
                if (byte_hit) begin
                    rdata <= {8'h00, dir[ioaddr[3:0]] ? out_reg[ioaddr[3:0]]
                                                      : in_reg[ioaddr[3:0]]};
                end else if (dir_hit) begin
                    rdata <= dir;
                end else begin
                    rdata <= 16'h0000;
                end
            end
        end
    end

endmodule

// File: tb/tb_io_scan_controller.sv
// Directed testbench for io_scan_controller. Cycle 0 is the IDLE cycle after reset is released.
module tb_io_scan_controller;

    logic        clk;
    logic        reset;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] ioaddr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rd_valid;
    logic [2:0]  p0_sel;
    logic [2:0]  p1_sel;
    logic [7:0]  p0_out;
    logic [7:0]  p1_out;
    logic        p0_oe;
    logic        p1_oe;
    logic [7:0]  p0_in;
    logic [7:0]  p1_in;
    logic        scan_done;
    logic [1:0]  state_dbg;

    int total;
    int bad;
    int cyc;
    bit sweep;

    io_scan_controller #(.SETTLE_CYC(2), .SLOT_W(3)) dut (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd),
        .ioaddr(ioaddr), .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid),
        .p0_sel(p0_sel), .p1_sel(p1_sel), .p0_out(p0_out), .p1_out(p1_out),
        .p0_oe(p0_oe), .p1_oe(p1_oe), .p0_in(p0_in), .p1_in(p1_in),
        .scan_done(scan_done), .state_dbg(state_dbg)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog timer
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary not yet printed");
        $fatal(1, "watchdog");
    end

    // Expected schedule: slot s is in SETUP at cycle 1+4s, in SETTLE at cycles 2+4s and 3+4s, and in SAMPLE at cycle 4+4s.
    function automatic int slot_of(input int c);
        return ((c - 1) / 4) % 8;
    endfunction

    function automatic int phase_of(input int c);
        return (c - 1) % 4;
    endfunction

    // Advance to the next sampling point (negedge). In sweep mode, p0_in follows the slot index.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (sweep) p0_in = 8'(slot_of(cyc));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io_wr = 1'b0;
        io_rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        ioaddr = a;
        wdata  = d;
        io_wr  = 1'b1;
        step();
        io_wr  = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [15:0] d, output logic v);
        ioaddr = a;
        io_rd  = 1'b1;
        step();
        io_rd  = 1'b0;
        d = rdata;
        v = rd_valid;
    endtask

    task automatic test_reset_scan();
        logic [15:0] d;
        logic        v;
        p0_in = 8'hA5;
        p1_in = 8'h3C;
        do_reset();
        total++;
        if (state_dbg !== 2'd0 || p0_sel !== 3'd0 || p1_sel !== 3'd0 || p0_out !== 8'h00 ||
            p1_out !== 8'h00 || rdata !== 16'h0000 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: state=%0d sel=%0d/%0d out=%h/%h rdata=%h rv=%b, required all 0",
                     state_dbg, p0_sel, p1_sel, p0_out, p1_out, rdata, rd_valid);
        end
        while (cyc <= 33) begin
            total++;
            if (scan_done !== (cyc == 32)) begin
                bad++;
                $display("FAIL scan_done cyc=%0d: got %b required %b", cyc, scan_done, cyc == 32);
            end
            total++;
            if (p0_oe !== 1'b0 || p1_oe !== 1'b0) begin
                bad++;
                $display("FAIL oe_idle cyc=%0d: got %b/%b required 0/0", cyc, p0_oe, p1_oe);
            end
            step();
        end
        do_read(16'h0000, d, v);
        total++;
        if (d !== 16'h00A5 || v !== 1'b1) begin
            bad++;
            $display("FAIL read_byte0: got %h v=%b required 00a5 v=1", d, v);
        end
        do_read(16'h0008, d, v);
        total++;
        if (d !== 16'h003C || v !== 1'b1) begin
            bad++;
            $display("FAIL read_byte8: got %h v=%b required 003c v=1", d, v);
        end
        p0_in = 8'h00;
        p1_in = 8'h00;
    endtask

    task automatic test_drive();
        logic [15:0] d;
        logic        v;
        int          sl;
        int          ph;
        logic        exp_oe;
        do_reset();
        do_write(16'h0010, 16'h0101);
        do_write(16'h0000, 16'h005A);
        do_write(16'h0008, 16'h00C3);
        while (cyc <= 40) begin
            sl = slot_of(cyc);
            ph = phase_of(cyc);
            exp_oe = (ph != 0) && (sl == 0);
            total++;
            if (p0_sel !== 3'(sl) || p1_sel !== 3'(sl)) begin
                bad++;
                $display("FAIL drive_sel cyc=%0d: got %0d/%0d required %0d", cyc, p0_sel, p1_sel, sl);
            end
            total++;
            if (p0_oe !== exp_oe || p1_oe !== exp_oe) begin
                bad++;
                $display("FAIL drive_oe cyc=%0d: got %b/%b required %b", cyc, p0_oe, p1_oe, exp_oe);
            end
            if (sl == 0) begin
                total++;
                if (p0_out !== 8'h5A || p1_out !== 8'hC3) begin
                    bad++;
                    $display("FAIL drive_out cyc=%0d: got %h/%h required 5a/c3", cyc, p0_out, p1_out);
                end
            end
            step();
        end
        do_read(16'h0000, d, v);
        total++;
        if (d !== 16'h005A || v !== 1'b1) begin
            bad++;
            $display("FAIL drive_read0: got %h v=%b required 005a v=1", d, v);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] d;
        logic        v;
        do_reset();
        sweep = 1'b1;
        while (cyc <= 33) begin
            if (cyc >= 1) begin
                total++;
                if (p0_sel !== 3'(slot_of(cyc))) begin
                    bad++;
                    $display("FAIL sweep_sel cyc=%0d: got %0d required %0d", cyc, p0_sel, slot_of(cyc));
                end
            end
            step();
        end
        for (int i = 0; i < 8; i++) begin
            do_read(16'(i), d, v);
            total++;
            if (d !== 16'(i) || v !== 1'b1) begin
                bad++;
                $display("FAIL sweep_in%0d: got %h v=%b required %h v=1", i, d, v, 16'(i));
            end
        end
        sweep = 1'b0;
        p0_in = 8'h00;
    endtask

    task automatic test_rw_same_cycle();
        logic [15:0] d;
        logic        v;
        do_reset();
        do_write(16'h0010, 16'h0008);
        do_write(16'h0003, 16'h0022);
        ioaddr = 16'h0003;
        wdata  = 16'h0011;
        io_wr  = 1'b1;
        io_rd  = 1'b1;
        step();
        io_wr = 1'b0;
        io_rd = 1'b0;
        total++;
        if (rdata !== 16'h0022 || rd_valid !== 1'b1) begin
            bad++;
            $display("FAIL rw_old: got %h v=%b required 0022 v=1", rdata, rd_valid);
        end
        step();
        total++;
        if (rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rw_pulse: rd_valid got %b required 0", rd_valid);
        end
        do_read(16'h0003, d, v);
        total++;
        if (d !== 16'h0011 || v !== 1'b1) begin
            bad++;
            $display("FAIL rw_new: got %h v=%b required 0011 v=1", d, v);
        end
    endtask

    task automatic test_reset_midscan();
        logic [15:0] d;
        logic        v;
        do_reset();
        do_write(16'h0010, 16'hFFFF);
        do_write(16'h0005, 16'h0077);
        do_read(16'h0005, d, v);
        total++;
        if (d !== 16'h0077) begin
            bad++;
            $display("FAIL mid_preread: got %h required 0077", d);
        end
        while (cyc < 22) step();
        total++;
        if (p0_sel !== 3'd5 || state_dbg !== 2'd2 || p0_oe !== 1'b1 || p0_out !== 8'h77) begin
            bad++;
            $display("FAIL mid_settle5: sel=%0d state=%0d oe=%b out=%h required 5/2/1/77",
                     p0_sel, state_dbg, p0_oe, p0_out);
        end
        reset = 1'b1;
        step();
        total++;
        if (state_dbg !== 2'd0 || p0_sel !== 3'd0 || p1_sel !== 3'd0 || p0_oe !== 1'b0 ||
            p1_oe !== 1'b0 || p0_out !== 8'h00 || p1_out !== 8'h00 || scan_done !== 1'b0 ||
            rdata !== 16'h0000 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: state=%0d sel=%0d/%0d oe=%b/%b out=%h/%h sd=%b rdata=%h rv=%b, required all 0",
                     state_dbg, p0_sel, p1_sel, p0_oe, p1_oe, p0_out, p1_out, scan_done, rdata, rd_valid);
        end
        reset = 1'b0;
        cyc = 0;
        do_read(16'h0010, d, v);
        total++;
        if (d !== 16'h0000 || v !== 1'b1) begin
            bad++;
            $display("FAIL mid_dir: got %h v=%b required 0000 v=1", d, v);
        end
    endtask

    task automatic test_unmapped();
        logic [15:0] d;
        logic        v;
        do_reset();
        do_write(16'h0010, 16'h00F1);
        do_write(16'h0004, 16'h0044);
        do_write(16'h0011, 16'hFFFF);
        do_write(16'h0100, 16'h0099);
        do_read(16'h0004, d, v);
        total++;
        if (d !== 16'h0044) begin
            bad++;
            $display("FAIL unmap_byte4: got %h required 0044", d);
        end
        do_read(16'h0020, d, v);
        total++;
        if (d !== 16'h0000 || v !== 1'b1) begin
            bad++;
            $display("FAIL unmap_read: got %h v=%b required 0000 v=1", d, v);
        end
        do_read(16'h0010, d, v);
        total++;
        if (d !== 16'h00F1) begin
            bad++;
            $display("FAIL unmap_dir: got %h required 00f1", d);
        end
        do_read(16'h0000, d, v);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("FAIL unmap_byte0: got %h required 0000", d);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cyc    = 0;
        sweep  = 1'b0;
        reset  = 1'b1;
        io_wr  = 1'b0;
        io_rd  = 1'b0;
        ioaddr = 16'h0000;
        wdata  = 16'h0000;
        p0_in  = 8'h00;
        p1_in  = 8'h00;
        test_reset_scan();
        test_drive();
        test_sweep();
        test_rw_same_cycle();
        test_reset_midscan();
        test_unmapped();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
